// File: rtl/bf16_div_pkg.sv
// bf16_div_pkg: shared widths, BF16 constants, slot-state enum and tag-width helper
//   BF16_W        BF16 word width
//   BF16_ONE/TWO  1.0 and 2.0 encodings
//   slot_t        per-requester slot state
//   clog2(n)      index width for n requesters, never below 1
package bf16_div_pkg;
   localparam int BF16_W = 16;
   localparam logic [BF16_W-1:0] BF16_ONE = 16'h3F80;
   localparam logic [BF16_W-1:0] BF16_TWO = 16'h4000;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} slot_t;
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req        request vector
//   ptr        highest-priority index this cycle
//   grant      one-hot grant, zero when nothing requests
//   grant_idx  index of the granted bit, zero when nothing requests
module rr_arbiter import bf16_div_pkg::*; #(
   parameter int N = 4
) (
   input  logic [N-1:0]          req,
   input  logic [clog2(N)-1:0]   ptr,
   output logic [N-1:0]          grant,
   output logic [clog2(N)-1:0]   grant_idx
);
   always_comb begin
      int j;
      j = 0;
      grant = '0;
      grant_idx = '0;
      // scan from the farthest offset down so the nearest requester wins
      for (int i = N - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % N;
         if (req[j]) begin
            grant = '0;
            grant[j] = 1'b1;
            grant_idx = clog2(N)'(j);
         end
      end
   end
endmodule

// File: rtl/bf16_div_scheduler.sv
// bf16_div_scheduler: shares one pipelined BF16 divider among NUM_REQ requesters
//   i_req_vld/o_req_rdy/i_req_a/i_req_b   per-requester request, round-robin accept
//   o_rsp_vld/i_rsp_rdy/o_rsp_res/o_rsp_exc per-requester result slot, held until consumed
//   o_div_vld/o_div_a/o_div_b              divider issue, one cycle after accept
//   i_div_vld/i_div_res/i_div_exc          divider return, DIV_LAT cycles after issue
//   o_err                                  sticky: divider valid disagreed with the tag pipe
module bf16_div_scheduler import bf16_div_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int DIV_LAT = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NUM_REQ-1:0]          i_req_vld,
   output logic [NUM_REQ-1:0]          o_req_rdy,
   input  logic [BF16_W*NUM_REQ-1:0]   i_req_a,
   input  logic [BF16_W*NUM_REQ-1:0]   i_req_b,
   output logic [NUM_REQ-1:0]          o_rsp_vld,
   input  logic [NUM_REQ-1:0]          i_rsp_rdy,
   output logic [BF16_W*NUM_REQ-1:0]   o_rsp_res,
   output logic [NUM_REQ-1:0]          o_rsp_exc,
   output logic                        o_div_vld,
   output logic [BF16_W-1:0]           o_div_a,
   output logic [BF16_W-1:0]           o_div_b,
   input  logic                        i_div_vld,
   input  logic [BF16_W-1:0]           i_div_res,
   input  logic                        i_div_exc,
   output logic                        o_err
);
   localparam int IW = clog2(NUM_REQ);
   localparam int QW = clog2(DIV_LAT + 1);
   slot_t               st [NUM_REQ];
   logic [BF16_W-1:0]   res [NUM_REQ];
   logic [NUM_REQ-1:0]  exc, elig, gnt;
   logic [IW-1:0]       ptr, gidx, iss_idx;
   logic [DIV_LAT-1:0]  tag_vld;
   logic [IW-1:0]       tag_idx [DIV_LAT];
   logic [QW-1:0]       quiet;
   logic                hit, mism;
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         elig[k] = i_req_vld[k] & (st[k] == ST_IDLE) & ~i_rst;
         o_rsp_vld[k] = st[k] == ST_DONE;
         o_rsp_res[BF16_W*k +: BF16_W] = res[k];
      end
   end
   assign o_req_rdy = gnt;
   assign o_rsp_exc = exc;
   assign hit = i_div_vld & tag_vld[DIV_LAT-1];
   // results left over from before reset may still emerge during the first DIV_LAT cycles
   assign mism = (i_div_vld != tag_vld[DIV_LAT-1]) && (quiet == '0);
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (elig),
      .ptr       (ptr),
      .grant     (gnt),
      .grant_idx (gidx)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            st[k] <= ST_IDLE;
            res[k] <= '0;
         end
         for (int i = 0; i < DIV_LAT; i++) tag_idx[i] <= '0;
         exc <= '0;
         ptr <= '0;
         iss_idx <= '0;
         tag_vld <= '0;
         o_div_vld <= 1'b0;
         o_div_a <= '0;
         o_div_b <= '0;
         quiet <= QW'(DIV_LAT);
         o_err <= 1'b0;
      end else begin
         o_div_vld <= |gnt;
         if (|gnt) begin
            ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
            o_div_a <= i_req_a[BF16_W*gidx +: BF16_W];
            o_div_b <= i_req_b[BF16_W*gidx +: BF16_W];
            iss_idx <= gidx;
         end
         tag_vld[0] <= o_div_vld;
         tag_idx[0] <= iss_idx;
         for (int i = 1; i < DIV_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
         if (quiet != '0) quiet <= quiet - 1'b1;
         if (mism) o_err <= 1'b1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (st[k] == ST_IDLE && gnt[k]) st[k] <= ST_BUSY;
            if (st[k] == ST_BUSY && hit && tag_idx[DIV_LAT-1] == IW'(k)) begin
               st[k] <= ST_DONE;
               res[k] <= i_div_res;
               exc[k] <= i_div_exc;
            end
            if (st[k] == ST_DONE && i_rsp_rdy[k]) st[k] <= ST_IDLE;
         end
      end
   end
endmodule
